tape_tap_player: RTL

Transmitter side of the Spectrum tape interface: drives the EAR/LOAD line `aud_in` with ROM-standard pulse timing generated from a byte stream, so TAP-style blocks load through the normal ROM loader without analog recording. Sits beside the sample-based tape recorder, fed by a block/byte source (flash/SD reader or BRAM), and shares the `aud_in` net through an external mux.

---
 rtl/tape_timing_pkg.sv | 26 ++
 rtl/tstate_tick_gen.sv | 31 +++
 rtl/tape_tap_player.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tape_timing_pkg.sv
// ROM-loader pulse timing constants and player state encoding for the TAP player.
package tape_timing_pkg;

  localparam int unsigned PILOT_T      = 2168;
  localparam int unsigned SYNC1_T      = 667;
  localparam int unsigned SYNC2_T      = 735;
  localparam int unsigned BIT0_T       = 855;
  localparam int unsigned BIT1_T       = 1710;
  localparam int unsigned PILOT_HDR_N  = 8063;
  localparam int unsigned PILOT_DATA_N = 3223;

  localparam int unsigned PULSE_CNT_W = 12;
  localparam int unsigned PILOT_CNT_W = 13;
  localparam int unsigned PAUSE_CNT_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLAG,
    ST_PILOT,
    ST_SYNC1,
    ST_SYNC2,
    ST_DATA,
    ST_PAUSE
  } tape_state_t;

endpackage

// File: rtl/tstate_tick_gen.sv
// Fractional clock divider: one-cycle tick at TSTATE_HZ on average from a CLK_FREQ clock.
module tstate_tick_gen #(
  parameter int unsigned CLK_FREQ  = 27000000,
  parameter int unsigned TSTATE_HZ = 3500000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned ACC_W = $clog2(2 * CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;

  assign acc_sum_c = acc + ACC_W'(TSTATE_HZ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum_c >= ACC_W'(CLK_FREQ)) begin
      acc  <= acc_sum_c - ACC_W'(CLK_FREQ);
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum_c;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tape_tap_player.sv
// Plays a TAP block (flag + data bytes) onto the EAR line with ROM-loader pulse timing.
module tape_tap_player
  import tape_timing_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 27000000,
  parameter int unsigned TSTATE_HZ   = 3500000,
  parameter int unsigned PAUSE_T     = 3500000,
  parameter int unsigned PILOT_LEN   = PILOT_T,
  parameter int unsigned SYNC1_LEN   = SYNC1_T,
  parameter int unsigned SYNC2_LEN   = SYNC2_T,
  parameter int unsigned BIT0_LEN    = BIT0_T,
  parameter int unsigned BIT1_LEN    = BIT1_T,
  parameter int unsigned HDR_PILOTS  = PILOT_HDR_N,
  parameter int unsigned DATA_PILOTS = PILOT_DATA_N
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        blk_start,
  input  logic [15:0] blk_len,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        stop,
  output logic        aud_in,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  tape_state_t            state;
  logic                   tick;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic [PILOT_CNT_W-1:0] pilot_left;
  logic [PAUSE_CNT_W-1:0] pause_cnt;
  logic [15:0]            bytes_left;
  logic [7:0]             cur_byte;
  logic [7:0]             nxt_byte;
  logic                   nxt_valid;
  logic [2:0]             bit_idx;
  logic                   half;
  logic                   stall;

  logic [PULSE_CNT_W-1:0] pulse_len_c;
  logic                   count_en_c;
  logic                   pulse_done_c;
  logic                   accept_c;

  tstate_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TSTATE_HZ(TSTATE_HZ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Current pulse length; cur_byte is shifted so bit 7 is always the bit on air.
  always_comb begin
    pulse_len_c = '0;
    case (state)
      ST_PILOT: pulse_len_c = PULSE_CNT_W'(PILOT_LEN);
      ST_SYNC1: pulse_len_c = PULSE_CNT_W'(SYNC1_LEN);
      ST_SYNC2: pulse_len_c = PULSE_CNT_W'(SYNC2_LEN);
      ST_DATA:  pulse_len_c = cur_byte[7] ? PULSE_CNT_W'(BIT1_LEN) : PULSE_CNT_W'(BIT0_LEN);
      default:  pulse_len_c = '0;
    endcase
    count_en_c   = tick && !stall && (state inside {ST_PILOT, ST_SYNC1, ST_SYNC2, ST_DATA});
    pulse_done_c = count_en_c && (pulse_cnt == pulse_len_c - PULSE_CNT_W'(1));
    accept_c     = byte_valid && byte_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      aud_in     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_ready <= 1'b0;
      underrun   <= 1'b0;
      pulse_cnt  <= '0;
      pilot_left <= '0;
      pause_cnt  <= '0;
      bytes_left <= '0;
      cur_byte   <= '0;
      nxt_byte   <= '0;
      nxt_valid  <= 1'b0;
      bit_idx    <= '0;
      half       <= 1'b0;
      stall      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= ST_IDLE;
        aud_in     <= 1'b1;
        busy       <= 1'b0;
        byte_ready <= 1'b0;
        nxt_valid  <= 1'b0;
        stall      <= 1'b0;
      end else begin
        if (pulse_done_c) begin
          pulse_cnt <= '0;
        end else if (count_en_c) begin
          pulse_cnt <= pulse_cnt + PULSE_CNT_W'(1);
        end

        case (state)
          ST_IDLE: begin
            if (blk_start) begin
              underrun <= 1'b0;
              if (blk_len == 16'd0) begin
                done <= 1'b1;
              end else begin
                state      <= ST_FLAG;
                busy       <= 1'b1;
                byte_ready <= 1'b1;
                bytes_left <= blk_len;
              end
            end
          end
          ST_FLAG: begin
            if (accept_c) begin
              cur_byte   <= byte_data;
              bytes_left <= bytes_left - 16'd1;
              byte_ready <= 1'b0;
              pilot_left <= byte_data[7] ? PILOT_CNT_W'(DATA_PILOTS) : PILOT_CNT_W'(HDR_PILOTS);
              pulse_cnt  <= '0;
              state      <= ST_PILOT;
            end
          end
          ST_PILOT: begin
            if (pulse_done_c) begin
              aud_in     <= ~aud_in;
              pilot_left <= pilot_left - PILOT_CNT_W'(1);
              if (pilot_left == PILOT_CNT_W'(1)) state <= ST_SYNC1;
            end
          end
          ST_SYNC1: begin
            if (pulse_done_c) begin
              aud_in <= ~aud_in;
              state  <= ST_SYNC2;
            end
          end
          ST_SYNC2: begin
            if (pulse_done_c) begin
              aud_in     <= ~aud_in;
              state      <= ST_DATA;
              bit_idx    <= '0;
              half       <= 1'b0;
              byte_ready <= (bytes_left != 16'd0);
            end
          end
          ST_DATA: begin
            if (stall) begin
              // Starved at a byte boundary: line and pulse counter frozen until the byte arrives.
              if (accept_c) begin
                cur_byte   <= byte_data;
                bytes_left <= bytes_left - 16'd1;
                stall      <= 1'b0;
                byte_ready <= (bytes_left != 16'd1);
              end
            end else begin
              if (accept_c) begin
                nxt_byte   <= byte_data;
                nxt_valid  <= 1'b1;
                bytes_left <= bytes_left - 16'd1;
                byte_ready <= 1'b0;
              end
              if (pulse_done_c) begin
                aud_in <= ~aud_in;
                half   <= ~half;
                if (half) begin
                  if (bit_idx == 3'd0) byte_ready <= 1'b0;
                  if (bit_idx == 3'd7) begin
                    bit_idx <= '0;
                    if (nxt_valid) begin
                      cur_byte   <= nxt_byte;
                      nxt_valid  <= 1'b0;
                      byte_ready <= (bytes_left != 16'd0);
                    end else if (bytes_left == 16'd0) begin
                      state     <= ST_PAUSE;
                      pause_cnt <= '0;
                    end else begin
                      stall      <= 1'b1;
                      underrun   <= 1'b1;
                      byte_ready <= 1'b1;
                    end
                  end else begin
                    bit_idx  <= bit_idx + 3'd1;
                    cur_byte <= {cur_byte[6:0], 1'b0};
                  end
                end
              end
            end
          end
          ST_PAUSE: begin
            if (tick) begin
              if (pause_cnt == PAUSE_CNT_W'(PAUSE_T - 1)) begin
                aud_in <= 1'b1;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                pause_cnt <= pause_cnt + PAUSE_CNT_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
